// File: rtl/rv_mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP, registered Moore outputs.
// Optional retired-instruction counter on instret when RV_CTRL_INSTRET_EN is defined.
module rv_mc_ctrl_fsm #(
  parameter int DEC_LAT     = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [37:0] instr_bus,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        trap_clr,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        illegal,
  output logic        retire,
  output logic [2:0]  state_o,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d, cls_dec;
  logic [2:0]  dec_cnt_q, dec_cnt_d;
  logic [7:0]  mem_cnt_q, mem_cnt_d;
  logic        imem_req_q, imem_req_d, ir_we_q, ir_we_d, pc_we_q, pc_we_d;
  logic [1:0]  pc_sel_q, pc_sel_d, wb_sel_q, wb_sel_d;
  logic        alu_a_sel_q, alu_a_sel_d, alu_b_sel_q, alu_b_sel_d;
  logic        reg_we_q, reg_we_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic        illegal_q, illegal_d, retire_q, retire_d;
  logic        bad_instr;

  // Exactly one legal bit must be set; bit 37 is a reserved slot.
  assign bad_instr = (instr_bus == 38'd0) ||
                     ((instr_bus & (instr_bus - 38'd1)) != 38'd0) || instr_bus[37];

  always_comb begin
    cls_dec = C_R;
    if (|instr_bus[18:10]) cls_dec = C_I;
    if (|instr_bus[23:19]) cls_dec = C_LD;
    if (|instr_bus[26:24]) cls_dec = C_ST;
    if (|instr_bus[32:27]) cls_dec = C_BR;
    if (instr_bus[33])     cls_dec = C_JAL;
    if (instr_bus[34])     cls_dec = C_JALR;
    if (instr_bus[35])     cls_dec = C_LUI;
    if (instr_bus[36])     cls_dec = C_AUIPC;
  end

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    dec_cnt_d   = dec_cnt_q;
    mem_cnt_d   = mem_cnt_q;
    ir_we_d     = 1'b0;
    pc_we_d     = 1'b0;
    retire_d    = 1'b0;
    pc_sel_d    = 2'd0;
    wb_sel_d    = 2'd0;
    reg_we_d    = 1'b0;
    alu_a_sel_d = 1'b0;
    alu_b_sel_d = 1'b0;
    case (state_q)
      S_FETCH: if (imem_ready) begin
        state_d   = S_DECODE;
        dec_cnt_d = 3'd0;
        ir_we_d   = 1'b1;
      end
      S_DECODE: begin
        if (dec_cnt_q == 3'(DEC_LAT - 1)) begin
          if (bad_instr) begin
            state_d = S_TRAP;
          end else begin
            cls_d   = cls_dec;
            state_d = S_EXEC;
          end
        end else begin
          dec_cnt_d = dec_cnt_q + 3'd1;
        end
      end
      S_EXEC: begin
        if (cls_q == C_BR) begin
          state_d = S_FETCH;
        end else if (cls_q == C_LD || cls_q == C_ST) begin
          state_d   = S_MEM;
          mem_cnt_d = 8'd0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          mem_cnt_d = 8'd0;
          if (cls_q == C_ST) begin
            state_d  = S_FETCH;
            pc_we_d  = 1'b1;
            retire_d = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (mem_cnt_q + 8'd1 == 8'(MEM_TIMEOUT)) begin
          mem_cnt_d = 8'd0;
          state_d   = S_TRAP;
        end else begin
          mem_cnt_d = mem_cnt_q + 8'd1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  if (trap_clr) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase

    // Output flops are loaded with the values belonging to the state being entered.
    if (state_d == S_EXEC) begin
      alu_a_sel_d = (cls_d == C_AUIPC) || (cls_d == C_JAL) || (cls_d == C_BR);
      alu_b_sel_d = !((cls_d == C_R) || (cls_d == C_BR));
      if (cls_d == C_BR) begin
        pc_we_d  = 1'b1;
        retire_d = 1'b1;
      end
    end
    if (state_d == S_WB) begin
      reg_we_d = 1'b1;
      pc_we_d  = 1'b1;
      retire_d = 1'b1;
      case (cls_d)
        C_LD:         wb_sel_d = 2'd1;
        C_JAL, C_JALR: wb_sel_d = 2'd2;
        C_LUI:        wb_sel_d = 2'd3;
        default:      wb_sel_d = 2'd0;
      endcase
      if (cls_d == C_JAL)  pc_sel_d = 2'd1;
      if (cls_d == C_JALR) pc_sel_d = 2'd2;
    end
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && (cls_d == C_ST);
    illegal_d  = (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      cls_q       <= C_R;
      dec_cnt_q   <= 3'd0;
      mem_cnt_q   <= 8'd0;
      imem_req_q  <= 1'b1;
      ir_we_q     <= 1'b0;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= 2'd0;
      alu_a_sel_q <= 1'b0;
      alu_b_sel_q <= 1'b0;
      reg_we_q    <= 1'b0;
      wb_sel_q    <= 2'd0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      illegal_q   <= 1'b0;
      retire_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      dec_cnt_q   <= dec_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
      imem_req_q  <= imem_req_d;
      ir_we_q     <= ir_we_d;
      pc_we_q     <= pc_we_d;
      pc_sel_q    <= pc_sel_d;
      alu_a_sel_q <= alu_a_sel_d;
      alu_b_sel_q <= alu_b_sel_d;
      reg_we_q    <= reg_we_d;
      wb_sel_q    <= wb_sel_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      illegal_q   <= illegal_d;
      retire_q    <= retire_d;
    end
  end

  // branch_taken only becomes valid inside EXEC, so the branch target select follows it there.
  assign pc_sel    = (state_q == S_EXEC && cls_q == C_BR) ? {1'b0, branch_taken} : pc_sel_q;
  assign imem_req  = imem_req_q;
  assign ir_we     = ir_we_q;
  assign pc_we     = pc_we_q;
  assign alu_a_sel = alu_a_sel_q;
  assign alu_b_sel = alu_b_sel_q;
  assign reg_we    = reg_we_q;
  assign wb_sel    = wb_sel_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign illegal   = illegal_q;
  assign retire    = retire_q;
  assign state_o   = state_q;

`ifdef RV_CTRL_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q + {31'd0, retire_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= 32'd0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: doc/rv_mc_ctrl_fsm.md
Name: rv_mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Consumes the decoder's one-hot instr_bus and sequences the datapath through fetch, decode, execute, memory and writeback: PC, IR, ALU operand muxes, register-file write and data-memory handshake.
- Flags illegal or undecodable instructions and data-memory timeouts as a trap.
- Sits between the decoder and the datapath muxes/enables.

Parameters:
- DEC_LAT, 2, cycles spent in DECODE before instr_bus is sampled (covers decoder register stages); legal range 1..7.
- MEM_TIMEOUT, 255, max cycles dmem_req may wait for dmem_ready before trapping; 8-bit counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instr_bus  in  38  decoder one-hot: [9:0] R-ALU, [18:10] I-ALU, [23:19] loads, [26:24] stores, [32:27] branches, [33] jal, [34] jalr, [35] lui, [36] auipc, [37] unused
- branch_taken  in  1  datapath comparator result, valid in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory done
- trap_clr  in  1  leaves TRAP, restarts at FETCH
- imem_req  out  1  instruction fetch request
- ir_we  out  1  IR load strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  2  0=pc+4, 1=pc+imm, 2=(rs1+imm)&~1
- alu_a_sel  out  1  0=rs1, 1=pc
- alu_b_sel  out  1  0=rs2, 1=imm
- reg_we  out  1  register-file write strobe
- wb_sel  out  2  0=alu, 1=mem, 2=pc+4, 3=imm
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store
- illegal  out  1  high while in TRAP
- retire  out  1  one-cycle pulse per completed instruction
- state_o  out  3  current state encoding
- instret  out  32  retired count (optional feature)

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- State, counters and all outputs are registered Moore outputs.
- Reset: state=FETCH. All outputs 0 except imem_req=1. Counters 0.
- Reset asserted mid-operation aborts immediately: no further strobes; a pending dmem_req drops asynchronously.

FETCH:
- imem_req=1.
- On imem_ready: ir_we=1 for one cycle, then go to DECODE with the decode counter cleared.

DECODE:
- Count DEC_LAT cycles, then sample instr_bus.
- If zero bits set, more than one bit set, or bit 37 set: go to TRAP.
- Otherwise latch the class and go to EXEC.

EXEC (exactly 1 cycle):
- alu_a_sel=1 for auipc, jal and branches; else 0.
- alu_b_sel=0 for R-type and branches; else 1.
- Branch: pc_we=1, pc_sel = branch_taken ? 1 : 0, retire=1, next state FETCH. Branch never writes registers.
- Load/store: next state MEM.
- All others: next state WB.

MEM:
- dmem_req=1; dmem_we=1 for stores. Both held stable until dmem_ready.
- Timeout counter increments each waiting cycle. When it reaches MEM_TIMEOUT without dmem_ready, go to TRAP.
- dmem_ready and timeout in the same cycle: ready wins.
- On ready:
  - store: pc_we=1, pc_sel=0, retire=1, next state FETCH.
  - load: next state WB.
- Counter clears on exit.

WB (1 cycle):
- reg_we=1, pc_we=1, retire=1, next state FETCH.
- wb_sel: loads=1; jal and jalr=2; lui=3; else 0.
- pc_sel: jal=1; jalr=2; else 0.

TRAP:
- illegal=1; all strobes 0.
- Stays in TRAP until trap_clr, then goes to FETCH. PC is not advanced.
- trap_clr in any other state is ignored.

Invariants:
- At most one of ir_we, reg_we, pc_we is asserted with dmem_req in any cycle.
- retire and pc_we coincide.

Optional Feature:
- Macro RV_CTRL_INSTRET_EN.
- Defined: instret is a 32-bit counter, increments on every retire pulse, wraps 0xFFFFFFFF to 0, reset to 0, unaffected by TRAP.
- Undefined: instret is tied to 0 and no counter logic is generated.

Test Plan:
- addi (bit 10), imem_ready after 3 cycles, DEC_LAT=2 -> FETCH(4 cycles), DECODE(2), EXEC(1), WB(1): reg_we=1, wb_sel=0, pc_sel=0, retire at cycle 8.
- beq (bit 27), branch_taken=1 -> EXEC asserts pc_we, pc_sel=1, retire; reg_we never asserted. With branch_taken=0, pc_sel=0.
- lw (bit 21), dmem_ready after 5 MEM cycles -> dmem_req high for exactly 5 cycles, then WB with wb_sel=1. sw (bit 26) -> dmem_we=1, no WB, retire on the ready cycle.
- instr_bus=0, then instr_bus=38'h3 -> TRAP each time, illegal=1 held for 10 cycles; trap_clr pulse -> FETCH next cycle with illegal=0.
- MEM_TIMEOUT=4, lw with dmem_ready never asserted -> TRAP after 4 MEM cycles. Repeat with dmem_ready on the 4th cycle -> WB, no trap.
- Assert rst_n=0 mid-MEM -> dmem_req drops without waiting for clk, state_o=0. With RV_CTRL_INSTRET_EN, 5 retired instructions -> instret=5; preload near 0xFFFFFFFF to check wrap to 0.
